// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the parametrised instruction memory.
//   - NOP_WORD_DEF : default fill word (clear sequence and out-of-range fetches)
//   - OP_*         : opcode values carried in the top 4 bits of an instruction
//   - state_e      : clear/ready state of the memory controller
//   - aw_min1()    : address width for a given depth, never less than 1 bit
package imem_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // Opcode field, instr[DATA_W-1 -: 4]
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int aw_min1(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x DATA_W storage, one synchronous write port and one
// synchronous read port. No reset on the array or the read register; the
// controller clears the contents itself after reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data
//   re     in   read enable; rdata updates only when set
//   raddr  in   read address (AW bits)
//   rdata  out  registered read data (old contents on a same-address write)
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_param.sv
// instr_mem_param: parametrised instruction memory for the fetch stage.
// After reset the array is filled with NOP_WORD, one word per cycle (busy=1),
// then fetches and loads are served. Fetch data is registered (1-cycle
// latency), held while stall=1, and bypassed from load_data when a load and a
// fetch hit the same in-range address in the same cycle.
// Ports:
//   clk          in   clock, posedge
//   rst_n        in   asynchronous reset, active low
//   load_en      in   write load_data to mem[load_addr]
//   load_addr    in   load address
//   load_data    in   load data
//   load_err     out  1-cycle pulse: load rejected (busy or out of range)
//   fetch_en     in   fetch request for addr
//   stall        in   hold instr/instr_valid
//   addr         in   fetch address
//   instr        out  fetched instruction
//   instr_valid  out  instr holds the result of an accepted fetch
//   addr_err     out  1-cycle pulse: accepted fetch had addr >= DEPTH
//   busy         out  clear sequence in progress
module instr_mem_param
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int RAM_AW = aw_min1(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable; compare stays unsigned.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              addr_err_q, addr_err_d;
  logic              load_err_q, load_err_d;
  // Output source: 1 = RAM read register, 0 = alt_q (NOP or bypassed load data)
  logic              src_ram_q, src_ram_d;
  logic [DATA_W-1:0] alt_q, alt_d;

  logic              clearing;
  logic              fetch_in_range;
  logic              load_in_range;
  logic              load_ok;
  logic              fetch_acc;
  logic              bypass;
  logic              ram_we;
  logic              ram_re;
  logic [RAM_AW-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign clearing       = (state_q == ST_CLEAR);
  assign fetch_in_range = ({1'b0, addr} < DEPTH_EXT);
  assign load_in_range  = ({1'b0, load_addr} < DEPTH_EXT);
  assign load_ok        = !clearing && load_en && load_in_range;
  assign fetch_acc      = !clearing && !stall && fetch_en;
  // Same-cycle write to the fetched word: RAM would return the old word.
  assign bypass         = load_ok && fetch_in_range && (load_addr == addr);
  assign ram_re         = fetch_acc && fetch_in_range && !bypass;

  // Clear sequence owns the write port; loads are rejected meanwhile.
  assign ram_we    = clearing || load_ok;
  assign ram_waddr = clearing ? clr_cnt_q[RAM_AW-1:0] : load_addr[RAM_AW-1:0];
  assign ram_wdata = clearing ? NOP_WORD : load_data;

  imem_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    src_ram_d  = src_ram_q;
    alt_d      = alt_q;
    addr_err_d = 1'b0;
    load_err_d = load_en && (clearing || !load_in_range);

    if (clearing) begin
      clr_cnt_d = clr_cnt_q + CNT_W'(1);
      valid_d   = 1'b0;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    end else if (!stall) begin
      valid_d = fetch_en;
      if (fetch_en) begin
        if (!fetch_in_range) begin
          addr_err_d = 1'b1;
          src_ram_d  = 1'b0;
          alt_d      = NOP_WORD;
        end else if (bypass) begin
          src_ram_d  = 1'b0;
          alt_d      = load_data;
        end else begin
          src_ram_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      load_err_q <= 1'b0;
      src_ram_q  <= 1'b0;
      alt_q      <= NOP_WORD;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
      load_err_q <= load_err_d;
      src_ram_q  <= src_ram_d;
      alt_q      <= alt_d;
    end
  end

  assign instr       = src_ram_q ? ram_rdata : alt_q;
  assign instr_valid = valid_q;
  assign addr_err    = addr_err_q;
  assign load_err    = load_err_q;
  assign busy        = busy_q;

endmodule
